// File: rtl/variance_cache_filler_pkg.sv
// Shared constants, state encoding and cache port structs for the variance-cache filler.
// The cache itself lives in the parent and is reached only through these structs.
package pkg_varianceCache;
    localparam int WORD_SIZE    = 32;
    localparam int WORD_SIZE_SQ = 64;
    localparam int ADDR_WIDTH   = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Window sum is TL - TR - BL + BR: corners 0 and 3 add, 1 and 2 subtract.
    function automatic logic corner_is_add(input logic [ADDR_WIDTH-1:0] addr);
        corner_is_add = (addr == 2'd0) || (addr == 2'd3);
    endfunction
endpackage

package structs;
    import pkg_varianceCache::*;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   waddr;
        logic [WORD_SIZE-1:0]    wdata;
        logic                    weSQ;
        logic [ADDR_WIDTH-1:0]   waddrSQ;
        logic [WORD_SIZE_SQ-1:0] wdataSQ;
    } struct_varianceCache_Write;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] raddr;
        logic [ADDR_WIDTH-1:0] raddrSQ;
    } struct_varianceCache_Read_in;

    typedef struct packed {
        logic [WORD_SIZE-1:0]    q;
        logic [WORD_SIZE_SQ-1:0] qSQ;
    } struct_varianceCache_Read_out;
endpackage

// File: rtl/variance_cache_filler.sv
// Writes four integral-image corners into the variance cache, reads them back and
// combines them into the window sum and squared sum (TL - TR - BL + BR).
module variance_cache_filler
    import pkg_varianceCache::*;
#(
    parameter int WORD_SIZE    = pkg_varianceCache::WORD_SIZE,
    parameter int WORD_SIZE_SQ = pkg_varianceCache::WORD_SIZE_SQ
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  corner_valid,
    output logic                                  corner_ready,
    input  logic [WORD_SIZE-1:0]                  corner_data,
    input  logic [WORD_SIZE_SQ-1:0]               corner_dataSq,
    output structs::struct_varianceCache_Write    vcw,
    output structs::struct_varianceCache_Read_in  vcr_in,
    input  structs::struct_varianceCache_Read_out vcr_out,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [WORD_SIZE-1:0]                  res_sum,
    output logic [WORD_SIZE_SQ-1:0]               res_sumSq
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic                    pend_q, pend_d;
    logic [WORD_SIZE-1:0]    acc_q, acc_d;
    logic [WORD_SIZE_SQ-1:0] acc_sq_q, acc_sq_d;
    logic                    accept_s;

    // Ready is held low while reset is asserted so no corner can slip in.
    assign corner_ready = (state_q == ST_FILL) && !rst;
    assign accept_s     = corner_valid && corner_ready;
    assign res_valid    = (state_q == ST_DONE);
    assign res_sum      = acc_q;
    assign res_sumSq    = acc_sq_q;

    // Next-state, counters and accumulator update
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pend_d      = 1'b0;
        pend_addr_d = rd_cnt_q;
        acc_d       = acc_q;
        acc_sq_d    = acc_sq_q;

        // Data read in the previous cycle arrives now; fold it in with its corner sign.
        if (pend_q) begin
            if (corner_is_add(pend_addr_q)) begin
                acc_d    = acc_q + vcr_out.q;
                acc_sq_d = acc_sq_q + vcr_out.qSQ;
            end else begin
                acc_d    = acc_q - vcr_out.q;
                acc_sq_d = acc_sq_q - vcr_out.qSQ;
            end
        end else begin
            acc_d    = acc_q;
            acc_sq_d = acc_sq_q;
        end

        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    if (fill_cnt_q == 2'd3) begin
                        state_d  = ST_READ;
                        rd_cnt_d = 2'd0;
                        acc_d    = '0;
                        acc_sq_d = '0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q;
                end
            end
            ST_READ: begin
                pend_d   = 1'b1;
                rd_cnt_d = rd_cnt_q + 2'd1;
                if (rd_cnt_q == 2'd3) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = 2'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d    = ST_FILL;
                fill_cnt_d = 2'd0;
            end
        endcase
    end

    // Cache write and read address drive; all fields idle at zero
    always_comb begin
        vcw    = '0;
        vcr_in = '0;
        if (accept_s) begin
            vcw.we      = 1'b1;
            vcw.waddr   = fill_cnt_q;
            vcw.wdata   = corner_data;
            vcw.weSQ    = 1'b1;
            vcw.waddrSQ = fill_cnt_q;
            vcw.wdataSQ = corner_dataSq;
        end else begin
            vcw.we   = 1'b0;
            vcw.weSQ = 1'b0;
        end
        if (state_q == ST_READ) begin
            vcr_in.raddr   = rd_cnt_q;
            vcr_in.raddrSQ = rd_cnt_q;
        end else begin
            vcr_in.raddr   = 2'd0;
            vcr_in.raddrSQ = 2'd0;
        end
    end

    // State registers; reset drops any partially processed window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= 2'd0;
            rd_cnt_q    <= 2'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= 2'd0;
            acc_q       <= '0;
            acc_sq_q    <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            acc_q       <= acc_d;
            acc_sq_q    <= acc_sq_d;
        end
    end

endmodule

// File: tb/tb_variance_cache_filler.sv
// Directed bench for variance_cache_filler with a window-level reference model
// and a small registered-read cache standing in for the parent's cache.
module tb_variance_cache_filler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        corner_valid = 1'b0;
    logic        corner_ready;
    logic [31:0] corner_data = 32'd0;
    logic [63:0] corner_dataSq = 64'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_sum;
    logic [63:0] res_sumSq;
    structs::struct_varianceCache_Write    vcw;
    structs::struct_varianceCache_Read_in  vcr_in;
    structs::struct_varianceCache_Read_out vcr_out;

    int total = 0;
    int bad   = 0;

    variance_cache_filler dut (
        .clk(clk), .rst(rst),
        .corner_valid(corner_valid), .corner_ready(corner_ready),
        .corner_data(corner_data), .corner_dataSq(corner_dataSq),
        .vcw(vcw), .vcr_in(vcr_in), .vcr_out(vcr_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_sumSq(res_sumSq)
    );

    always #5 clk = ~clk;

    // Stand-in cache: synchronous write, registered read
    logic [31:0] mem   [4];
    logic [63:0] mem_sq[4];
    always @(posedge clk) begin
        if (vcw.we)   mem[vcw.waddr]       <= vcw.wdata;
        if (vcw.weSQ) mem_sq[vcw.waddrSQ]  <= vcw.wdataSQ;
        vcr_out.q   <= mem[vcr_in.raddr];
        vcr_out.qSQ <= mem_sq[vcr_in.raddrSQ];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Window-level model: collect four corners, then result is due 6 cycles later
    int          cyc = 0;
    int          m_n = 0;
    logic        m_busy = 1'b0;
    int          m_t4 = 0;
    logic [31:0] m_d[4];
    logic [63:0] m_s[4];
    logic [31:0] m_sum;
    logic [63:0] m_sumsq;
    logic        exp_ready, exp_we, exp_valid, prev_valid = 1'b0;
    int          k;
    int          n_results = 0;
    int          dut_lat = 0;
    logic [31:0] got_sum;
    logic [63:0] got_sumsq;

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_ready", corner_ready, 1'b0);
            check("rst_we", vcw.we | vcw.weSQ, 1'b0);
            check("rst_valid", res_valid, 1'b0);
            check("rst_sum", res_sum, 32'd0);
            check("rst_sumsq", res_sumSq, 64'd0);
            m_n = 0;
            m_busy = 1'b0;
            prev_valid = 1'b0;
        end else begin
            exp_ready = !m_busy;
            exp_we    = corner_valid && exp_ready;
            k         = cyc - m_t4;
            exp_valid = m_busy && (k >= 6);
            check("ready", corner_ready, exp_ready);
            check("we", vcw.we, exp_we);
            check("weSQ", vcw.weSQ, exp_we);
            if (exp_we) begin
                check("waddr", vcw.waddr, m_n[1:0]);
                check("waddrSQ", vcw.waddrSQ, m_n[1:0]);
                check("wdata", vcw.wdata, corner_data);
                check("wdataSQ", vcw.wdataSQ, corner_dataSq);
            end
            if (m_busy && k >= 1 && k <= 4) begin
                check("raddr", vcr_in.raddr, k - 1);
                check("raddrSQ", vcr_in.raddrSQ, k - 1);
            end
            check("res_valid", res_valid, exp_valid);
            if (exp_valid) begin
                check("res_sum", res_sum, m_sum);
                check("res_sumSq", res_sumSq, m_sumsq);
            end
            if (res_valid && !prev_valid && m_busy) dut_lat = k;
            prev_valid = res_valid;
            if (exp_we) begin
                m_d[m_n] = corner_data;
                m_s[m_n] = corner_dataSq;
                m_n++;
                if (m_n == 4) begin
                    m_n     = 0;
                    m_busy  = 1'b1;
                    m_t4    = cyc;
                    m_sum   = m_d[0] - m_d[1] - m_d[2] + m_d[3];
                    m_sumsq = m_s[0] - m_s[1] - m_s[2] + m_s[3];
                end
            end
            if (exp_valid && res_ready) begin
                got_sum   = res_sum;
                got_sumsq = res_sumSq;
                n_results++;
                m_busy = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!corner_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", corner_ready, 1'b1);
    endtask

    // d/s/gaps packed with corner 0 (TL) in the lowest slice
    task automatic send_window(input logic [3:0][31:0] d, input logic [3:0][63:0] s,
                               input logic [3:0][3:0] gaps);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[i]); g++) begin
                corner_valid = 1'b0;
                @(posedge clk); #1;
            end
            wait_ready();
            corner_valid  = 1'b1;
            corner_data   = d[i];
            corner_dataSq = s[i];
            @(posedge clk); #1;
        end
        corner_valid = 1'b0;
    endtask

    task automatic wait_result(input int hold);
        int n = 0;
        res_ready = (hold == 0);
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_wait", res_valid, 1'b1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("back_to_fill", corner_ready, 1'b1);
        check("valid_dropped", res_valid, 1'b0);
    endtask

    int res_before;

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lit_valid", res_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_lit_ready", corner_ready, 1'b1);
        @(posedge clk); #1;

        // Basic window, immediate acceptance of the result
        send_window({32'd100, 32'd40, 32'd30, 32'd10},
                    {64'd10000, 64'd1600, 64'd900, 64'd100}, 16'h0000);
        wait_result(0);
        check("w1_sum", got_sum, 32'd40);
        check("w1_sumsq", got_sumsq, 64'd7600);
        check("w1_lat", dut_lat, 6);

        // Modulo wrap to all ones
        send_window({32'd0, 32'd0, 32'd1, 32'd0}, {64'd0, 64'd0, 64'd1, 64'd0}, 16'h0000);
        wait_result(0);
        check("wrap_sum", got_sum, 32'hFFFF_FFFF);
        check("wrap_sumsq", got_sumsq, 64'hFFFF_FFFF_FFFF_FFFF);

        // Valid pattern 1,0,0,1,1,0,1 and result held back for 5 cycles
        send_window({32'd7, 32'd2, 32'd3, 32'd20}, {64'd49, 64'd4, 64'd9, 64'd400}, 16'h1020);
        wait_result(5);
        check("gap_sum", got_sum, 32'd22);
        check("gap_sumsq", got_sumsq, 64'd436);
        check("hold_lat", dut_lat, 6);

        // Reset during the second READ cycle discards the window
        res_before = n_results;
        res_ready = 1'b1;
        send_window({32'd4, 32'd3, 32'd2, 32'd1}, {64'd16, 64'd9, 64'd4, 64'd1}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        send_window({32'd5, 32'd1, 32'd1, 32'd5}, {64'd25, 64'd1, 64'd1, 64'd25}, 16'h0000);
        wait_result(0);
        check("abort_count", n_results - res_before, 1);
        check("abort_sum", got_sum, 32'd8);
        check("abort_sumsq", got_sumsq, 64'd48);

        // Back-to-back windows
        send_window({32'd9, 32'd2, 32'd3, 32'd11}, {64'd81, 64'd4, 64'd9, 64'd121}, 16'h0000);
        wait_result(0);
        check("b2b1_sum", got_sum, 32'd15);
        send_window({32'd50, 32'd5, 32'd6, 32'd1}, {64'd2500, 64'd25, 64'd36, 64'd1}, 16'h0000);
        wait_result(0);
        check("b2b2_sum", got_sum, 32'd40);
        check("b2b2_sumsq", got_sumsq, 64'd2440);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
